// File: rtl/mult_operand_sequencer.sv
// Operand front-end for the shift-and-add multiplier: buffers signed operand pairs,
// issues their magnitudes to the multiplier, and returns the sign-corrected product.
module mult_operand_sequencer #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 4,
   parameter int MUL_LATENCY = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic [WIDTH-1:0]         mul_x,
   output logic [WIDTH-1:0]         mul_y,
   output logic                     mul_start,
   input  logic [2*WIDTH-1:0]       mul_product,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH-1:0]       out_product,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MUL_LATENCY + 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAT_LOAD   = CW'(MUL_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_OUTPUT = 2'd3
   } state_t;

   // Handshakes: a transfer occurs on a rising edge where valid and ready are both
   // high; valid never waits on ready, and payload is held while valid && !ready.

   state_t                 r_state;
   logic [WIDTH-1:0]       r_mem_a [DEPTH];
   logic [WIDTH-1:0]       r_mem_b [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [AW:0]            r_count;
   logic [WIDTH-1:0]       r_mul_x;
   logic [WIDTH-1:0]       r_mul_y;
   logic                   r_neg;
   logic                   r_mul_start;
   logic [CW-1:0]          r_lat_cnt;
   logic                   r_out_valid;
   logic [2*WIDTH-1:0]     r_out_product;

   logic                   w_push;
   logic                   w_pop;
   logic [WIDTH-1:0]       w_head_a;
   logic [WIDTH-1:0]       w_head_b;
   logic [WIDTH-1:0]       w_abs_a;
   logic [WIDTH-1:0]       w_abs_b;
   logic [2*WIDTH-1:0]     w_signed_product;

   assign in_ready = !rst && (r_count != FULL_COUNT);
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

   assign w_head_a = r_mem_a[r_rd_ptr];
   assign w_head_b = r_mem_b[r_rd_ptr];
   // The most negative operand negates to itself, which read unsigned is its magnitude.
   assign w_abs_a  = w_head_a[WIDTH-1] ? -w_head_a : w_head_a;
   assign w_abs_b  = w_head_b[WIDTH-1] ? -w_head_b : w_head_b;
   assign w_signed_product = r_neg ? -mul_product : mul_product;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_mul_x       <= '0;
         r_mul_y       <= '0;
         r_neg         <= 1'b0;
         r_mul_start   <= 1'b0;
         r_lat_cnt     <= '0;
         r_out_valid   <= 1'b0;
         r_out_product <= '0;
      end else begin
         r_mul_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_mul_x     <= w_abs_a;
                  r_mul_y     <= w_abs_b;
                  r_neg       <= w_head_a[WIDTH-1] ^ w_head_b[WIDTH-1];
                  r_mul_start <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_lat_cnt <= LAT_LOAD;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // Counter reaches zero on the edge the multiplier result becomes valid.
               if (r_lat_cnt == '0) begin
                  r_out_product <= w_signed_product;
                  r_out_valid   <= 1'b1;
                  r_state       <= S_OUTPUT;
               end else begin
                  r_lat_cnt <= r_lat_cnt - CW'(1);
               end
            end
            S_OUTPUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mul_x       = r_mul_x;
   assign mul_y       = r_mul_y;
   assign mul_start   = r_mul_start;
   assign out_valid   = r_out_valid;
   assign out_product = r_out_product;
   assign fifo_count  = r_count;
   assign busy        = (r_state != S_IDLE) || (r_count != '0);
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a fixed-latency multiplier model
// that holds a poison value on mult until its latency has elapsed.
module tb_mult_operand_sequencer;

   localparam int WIDTH       = 16;
   localparam int MUL_LATENCY = 17;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a;
   logic [WIDTH-1:0]  in_b;
   logic [WIDTH-1:0]  mul_x;
   logic [WIDTH-1:0]  mul_y;
   logic              mul_start;
   logic [31:0]       mul_product;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_product;
   logic              busy;
   logic [2:0]        fifo_count;
   logic [1:0]        dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   mult_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .MUL_LATENCY(MUL_LATENCY)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mul_x       (mul_x),
      .mul_y       (mul_y),
      .mul_start   (mul_start),
      .mul_product (mul_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Multiplier model: samples x/y on start, mult becomes valid MUL_LATENCY edges later.
   logic [31:0]      m_pend;
   logic [WIDTH-1:0] m_x;
   logic [WIDTH-1:0] m_y;
   int               m_cnt;
   int               start_edges = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt       <= 0;
         mul_product <= 32'hDEADBEEF;
      end else if (mul_start) begin
         checks++;
         if (m_cnt != 0) begin
            failures++;
            $display("FAIL restart_in_wait: start seen with %0d latency cycles left, required 0", m_cnt);
         end
         start_edges++;
         m_x         <= mul_x;
         m_y         <= mul_y;
         m_pend      <= {16'h0, mul_x} * {16'h0, mul_y};
         m_cnt       <= MUL_LATENCY;
         mul_product <= 32'hDEADBEEF;
      end else if (m_cnt != 0) begin
         checks++;
         if (mul_x !== m_x || mul_y !== m_y) begin
            failures++;
            $display("FAIL operand_stability: mul_x=%0d mul_y=%0d, required %0d %0d", mul_x, mul_y, m_x, m_y);
         end
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) mul_product <= m_pend;
      end
   end

   // driver tasks
   task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit ok);
      ok       = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready_low: got %b required 0", in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready_high: got %b required 1", in_ready);
      end
      checks++;
      if (mul_x !== 16'h0 || mul_y !== 16'h0 || mul_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_mul_outputs: x=%0h y=%0h start=%b required 0 0 0", mul_x, mul_y, mul_start);
      end
      checks++;
      if (out_valid !== 1'b0 || out_product !== 32'h0) begin
         failures++;
         $display("FAIL reset_out: valid=%b product=%0h required 0 0", out_valid, out_product);
      end
      checks++;
      if (busy !== 1'b0 || fifo_count !== 3'd0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_status: busy=%b count=%0d state=%0d required 0 0 0", busy, fifo_count, dbg_state);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      bit ok;
      int lat;
      int s0;
      s0 = start_edges;
      send_pair(16'd45, 16'd40, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_accept: pair not accepted, required accepted");
      end
      wait_valid(lat);
      checks++;
      if (lat != 19) begin
         failures++;
         $display("FAIL basic_latency: got %0d edges required 19", lat);
      end
      checks++;
      if (out_product !== 32'd1800) begin
         failures++;
         $display("FAIL basic_product: got %0d required 1800", out_product);
      end
      checks++;
      if (m_x !== 16'd45 || m_y !== 16'd40) begin
         failures++;
         $display("FAIL basic_operands: x=%0d y=%0d required 45 40", m_x, m_y);
      end
      checks++;
      if (start_edges - s0 != 1) begin
         failures++;
         $display("FAIL basic_start_pulse: got %0d start cycles required 1", start_edges - s0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_drain: valid=%b busy=%b required 0 0", out_valid, busy);
      end
   endtask

   task automatic test_signed;
      bit ok;
      int lat;
      send_pair(-16'sd420, 16'sd69, ok);
      wait_valid(lat);
      checks++;
      if (m_x !== 16'd420 || m_y !== 16'd69) begin
         failures++;
         $display("FAIL signed_operands: x=%0d y=%0d required 420 69", m_x, m_y);
      end
      checks++;
      if (out_product !== 32'hFFFF8ECC) begin
         failures++;
         $display("FAIL signed_product: got %0h required ffff8ecc", out_product);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_corners;
      bit ok;
      int lat;
      send_pair(16'h8000, 16'h8000, ok);
      wait_valid(lat);
      checks++;
      if (mul_x !== 16'h8000 || mul_y !== 16'h8000) begin
         failures++;
         $display("FAIL corner_min_operands: x=%0h y=%0h required 8000 8000", mul_x, mul_y);
      end
      checks++;
      if (out_product !== 32'h40000000) begin
         failures++;
         $display("FAIL corner_min_product: got %0h required 40000000", out_product);
      end
      @(posedge clk);
      #1;
      send_pair(16'd0, -16'sd5, ok);
      wait_valid(lat);
      checks++;
      if (m_x !== 16'd0 || m_y !== 16'd5) begin
         failures++;
         $display("FAIL corner_zero_operands: x=%0d y=%0d required 0 5", m_x, m_y);
      end
      checks++;
      if (out_product !== 32'h0 || lat != 19) begin
         failures++;
         $display("FAIL corner_zero_product: got %0h after %0d edges required 0 after 19", out_product, lat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_pressure;
      logic [WIDTH-1:0] pa [6];
      logic [WIDTH-1:0] pb [6];
      int idx;
      int lat;
      int ready_cyc;
      int n_res;
      int t_res [5];
      bit stable;
      bit will_accept;
      pa = '{16'd202, -16'sd3, 16'd100,   -16'sd1, 16'd12345, 16'd7};
      pb = '{16'd1500, 16'd7,  -16'sd100, -16'sd1, 16'd2,     16'd8};
      exp_q.delete();
      exp_q.push_back(32'hFFFFFFEB);
      exp_q.push_back(32'hFFFFD8F0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd24690);
      exp_q.push_back(32'd56);

      out_ready = 1'b0;
      idx       = 0;
      in_valid  = 1'b1;
      in_a      = pa[0];
      in_b      = pb[0];
      for (int c = 0; c < 20 && idx < 6; c++) begin
         @(negedge clk);
         if (!in_ready) break;
         @(posedge clk);
         #1;
         idx++;
         if (idx < 6) begin
            in_a = pa[idx];
            in_b = pb[idx];
         end
      end
      checks++;
      if (idx != 5) begin
         failures++;
         $display("FAIL bp_accepted: got %0d pairs required 5", idx);
      end
      checks++;
      if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
         failures++;
         $display("FAIL bp_full: in_ready=%b count=%0d required 0 4", in_ready, fifo_count);
      end

      wait_valid(lat);
      checks++;
      if (out_product !== 32'd303000) begin
         failures++;
         $display("FAIL bp_first_product: got %0d required 303000", out_product);
      end
      stable = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || out_product !== 32'd303000 || fifo_count !== 3'd4) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL bp_hold: valid=%b product=%0d count=%0d required 1 303000 4", out_valid, out_product, fifo_count);
      end

      out_ready   = 1'b1;
      ready_cyc   = 0;
      n_res       = 0;
      will_accept = 1'b0;
      for (int c = 1; c <= 200 && n_res < 5; c++) begin
         @(posedge clk);
         #1;
         if (will_accept) in_valid = 1'b0;
         will_accept = in_valid && in_ready;
         if (in_ready && ready_cyc == 0) begin
            ready_cyc = c;
            checks++;
            if (fifo_count !== 3'd3 || c != 2) begin
               failures++;
               $display("FAIL bp_ready_return: count=%0d at edge %0d required 3 at edge 2", fifo_count, c);
            end
         end
         if (out_valid) begin
            t_res[n_res] = c;
            n_res++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL bp_extra_result: got %0h required none", out_product);
            end else if (out_product !== exp_q[0]) begin
               failures++;
               $display("FAIL bp_order: got %0h required %0h", out_product, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
      end
      checks++;
      if (n_res != 5 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL bp_result_count: got %0d results required 5", n_res);
      end
      checks++;
      if (n_res < 3 || t_res[1] - t_res[0] != MUL_LATENCY + 3) begin
         failures++;
         $display("FAIL bp_throughput: interval %0d edges required %0d", (n_res < 3) ? 0 : t_res[1] - t_res[0], MUL_LATENCY + 3);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_wait;
      bit ok;
      int lat;
      int seen_valid;
      out_ready = 1'b1;
      send_pair(16'd11, 16'd13, ok);
      send_pair(16'd21, 16'd23, ok);
      send_pair(16'd31, 16'd33, ok);
      checks++;
      if (fifo_count !== 3'd2 || dbg_state !== 2'd2) begin
         failures++;
         $display("FAIL rst_setup: count=%0d state=%0d required 2 2", fifo_count, dbg_state);
      end
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (fifo_count !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0 || mul_start !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_abort: count=%0d busy=%b valid=%b start=%b ready=%b required 0 0 0 0 0",
                  fifo_count, busy, out_valid, mul_start, in_ready);
      end
      seen_valid = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid++;
      end
      rst = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid++;
      end
      checks++;
      if (seen_valid != 0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL rst_flushed: valid cycles=%0d busy=%b count=%0d required 0 0 0", seen_valid, busy, fifo_count);
      end
      send_pair(16'd3, -16'sd7, ok);
      wait_valid(lat);
      checks++;
      if (out_product !== 32'hFFFFFFEB || lat != 19) begin
         failures++;
         $display("FAIL rst_recover: got %0h after %0d edges required ffffffeb after 19", out_product, lat);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_corners();
      test_back_pressure();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_operand_sequencer.md
# mult_operand_sequencer

Front-end stage that feeds the shift-and-add (Russian peasant) `Multiplier` and returns its result. It accepts signed 16-bit operand pairs over a valid/ready stream and buffers them in a small FIFO. For each pair it drives the multiplier's unsigned `x`/`y`/`start` inputs with the operand magnitudes, waits the multiplier's fixed latency, and captures the 32-bit `mult`. It then re-applies the sign and presents a signed 32-bit product on a valid/ready output stream.

## Interface
- `WIDTH`, 16: operand width. Product width is 2*`WIDTH`.
- `DEPTH`, 4: operand FIFO entries (power of two).
- `MUL_LATENCY`, 17: cycles from the edge where the multiplier samples `start`=1 to the edge where `mult` is valid.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept a pair. Equals `count < DEPTH`; forced 0 while `rst` is high.
- `in_a`, `in_b` in `WIDTH`: signed two's-complement operands.
- `mul_x`, `mul_y` out `WIDTH`: unsigned magnitudes to `Multiplier.x`/`.y`. Held stable from issue until capture.
- `mul_start` out 1: one-cycle start pulse to `Multiplier.start`.
- `mul_product` in 2*`WIDTH`: `Multiplier.mult`.
- `out_valid` out 1: signed result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_product` out 2*`WIDTH`: signed product.
- `busy` out 1: state is not IDLE, or FIFO is non-empty.
- `fifo_count` out clog2(`DEPTH`)+1: current FIFO occupancy.

## Operation
- FIFO:
  - Push on `in_valid && in_ready`.
  - Pop only in IDLE.
  - Full FIFO: no push (no pass-through).
  - Simultaneous push and pop when not full: count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
  - IDLE:
    - If the FIFO is non-empty, pop the head and go to ISSUE.
    - Register `mul_x`=|a| and `mul_y`=|b|; |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned.
    - Register `neg` = a[MSB] ^ b[MSB].
  - ISSUE:
    - `mul_start`=1 for exactly this cycle.
    - Load down-counter to `MUL_LATENCY`−1; go to WAIT.
  - WAIT:
    - Counter decrements each edge.
    - On the edge where the counter equals 0, capture `out_product` = neg ? −`mul_product` : `mul_product`, and go to OUTPUT.
  - OUTPUT:
    - `out_valid`=1.
    - On `out_ready`, go to IDLE, which may pop on the following edge.
    - `out_product` stays stable while `out_valid && !out_ready`.
- Arithmetic:
  - The magnitude product is at most 2^(2·WIDTH−2), so the signed result never overflows.
  - Negating 0 yields 0.
- One operation is in flight at a time. The multiplier is never restarted while in WAIT.

## Timing
- Reset values: `in_ready`=0 during reset and 1 on the first cycle after release. `mul_x`=0, `mul_y`=0, `mul_start`=0, `out_valid`=0, `out_product`=0, `busy`=0, `fifo_count`=0, state IDLE.
- Latency, with the pair accepted at edge E0 into an empty, idle block:
  - E1: pop; state goes to ISSUE.
  - Cycle after E1: `mul_start` high.
  - E2: the multiplier samples `start`.
  - E2+`MUL_LATENCY`: capture.
  - `out_valid` is high from E2+`MUL_LATENCY` onward, i.e. 19 edges after acceptance at default parameters.
- Throughput: one result per `MUL_LATENCY`+3 cycles when `out_ready` is held high.
- Reset mid-operation:
  - Aborts immediately and flushes the FIFO.
  - Any in-flight result is discarded; `mul_start` drops.
  - The multiplier shares `rst` and is reset with the sequencer.
- `in_valid` while full: the pair is not accepted, and the source must hold it.
- A push into an empty FIFO and a pop cannot coincide, since a pop requires a non-empty FIFO at the edge.

## Test plan
Bench instantiates this block driving the team `Multiplier` (same `clk`/`rst`) and checks `mul_x`/`mul_y` stability during WAIT.
- **Basic product:** reset 5 cycles, then one pair a=45, b=40, `out_ready`=1.
  - Expect `mul_start` exactly one cycle and `mul_x`=45, `mul_y`=40.
  - Expect `out_product`=1800, `out_valid` 19 edges after acceptance.
- **Signed pair:** a=−420, b=69.
  - Expect `mul_x`=420, `mul_y`=69.
  - Expect `out_product`=0xFFFF8ECC (−28980).
- **Corner magnitudes:**
  - a=−32768, b=−32768: expect `mul_x`=0x8000 and `out_product`=0x40000000.
  - a=0, b=−5: expect `out_product`=0.
- **Back-pressure:** `out_ready`=0; offer 6 pairs back-to-back, starting with (202, 1500).
  - Expect 5 accepted, then `in_ready`=0 and `fifo_count`=4.
  - First result 303000 is held stable.
  - Raise `out_ready`: results emerge in order, and `in_ready` returns to 1 after the first pop.
- **Reset mid-WAIT:** assert `rst` 5 cycles after `mul_start`, with 2 pairs queued.
  - Expect `fifo_count`=0, `out_valid` never asserted for those pairs, and `busy`=0.
  - After release, pair (3, −7) yields −21.
